lsu_mem_port: RTL
=================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, default 16, maximum WAIT cycles without dmem_ack before abort.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 The clock port SHALL be: clk  in  1  rising-edge clock.
REQ-004 The reset port SHALL be: reset  in  1  synchronous active-high reset.
REQ-005 The port memread SHALL be: memread  in  1  load request from decode.
REQ-006 The port memwrite SHALL be: memwrite  in  1  store request from decode.
REQ-007 The port loadcntrl SHALL be: loadcntrl  in  5  one-hot load type; bit4..0 = lhu,lbu,lw,lh,lb.
REQ-008 The port storecntrl SHALL be: storecntrl  in  3  one-hot store type; bit2..0 = sw,sh,sb.
REQ-009 The ports addr and wdata SHALL be: addr  in  32  effective byte address; wdata  in  32  store data (rs2).
REQ-010 The memory-side outputs SHALL be: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned, [1:0]=0); dmem_be  out  4; dmem_wdata  out  32.
REQ-011 The memory-side inputs SHALL be: dmem_ack  in  1  one-cycle completion; dmem_rdata  in  32  read word, valid with ack.
REQ-012 The pipeline-side outputs SHALL be: rdata  out  32  extended load result; rdata_valid  out  1; busy  out  1 (OR'd into hazard); fault  out  1  one-cycle pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE, a legal request (exactly one of memread/memwrite, matching cntrl one-hot, aligned addr) SHALL:
- latch addr, be, wdata and load type;
- drive busy=1 combinationally in the same cycle;
- move to WAIT.
REQ-015 In WAIT, dmem_req SHALL be 1, with dmem_we/addr/be/wdata held stable until dmem_ack.
REQ-016 On dmem_ack in WAIT:
- load: register the extended dmem_rdata into rdata and go to RESP;
- store: go directly to IDLE.
REQ-017 In RESP, rdata_valid SHALL be 1 for exactly one cycle with busy=0, then the FSM SHALL return to IDLE; rdata SHALL hold its value until the next load completes.
REQ-018 busy SHALL be 1 in WAIT and 0 in IDLE (apart from REQ-014) and in RESP.
REQ-019 Minimum load latency SHALL be: request in cycle n, ack in n+1, rdata_valid in n+2.
REQ-020 Byte enables and write data SHALL be:
- sb: be=1<<addr[1:0], wdata[7:0] replicated x4;
- sh: be=addr[1]?1100:0011, wdata[15:0] replicated x2;
- sw: be=1111;
- loads: be=1111 with dmem_we=0.
REQ-021 Load extraction SHALL select the byte lane addr[1:0] or the half lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word unchanged.
REQ-022 The following SHALL pulse fault on the next cycle, issue no dmem_req, and leave the FSM in IDLE:
- misaligned access: lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]!=0;
- memread and memwrite both high;
- cntrl not one-hot.
REQ-023 An 8-bit wait counter SHALL clear on entry to WAIT; if it reaches TIMEOUT without ack, the block SHALL drop dmem_req, pulse fault and return to IDLE.
REQ-024 Requests presented while not in IDLE SHALL be ignored; decode is held by busy.
REQ-025 dmem_ack outside WAIT SHALL be ignored.
REQ-026 dmem_ack arriving in the same cycle the timeout expires SHALL take precedence (normal completion, no fault).

Reset
REQ-027 Reset SHALL force state=IDLE, counter=0, and all outputs (dmem_*, rdata, rdata_valid, busy, fault) to 0 on the next edge.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction: no rdata_valid and no fault, with dmem_req=0 from the following cycle.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum, the loadcntrl/storecntrl bit-index constants and the default TIMEOUT.
REQ-030 Byte-lane/byte-enable generation and load extension SHALL live in one combinational sub-module, lsu_align; the FSM and counter SHALL live in lsu_mem_port.

Verification
REQ-031 The bench SHALL run the lb sign-extension case: lb addr=0x103, ack next cycle, rdata_in=0x80FF_FF12 -> rdata=0xFFFF_FF80, rdata_valid at n+2.
REQ-032 The bench SHALL run the sh upper-half case: sh addr=0x202, wdata=0x0000_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x200, dmem_we=1.
REQ-033 The bench SHALL run the misaligned-load case: lw addr=0x101 -> fault pulses one cycle, dmem_req stays 0, busy=0 in the following cycle.
REQ-034 The bench SHALL run the timeout case: TIMEOUT=4, no ack -> dmem_req high 4 cycles, then fault=1 and return to IDLE; a late ack is ignored.
REQ-035 The bench SHALL run the held-ack load: lhu addr=0x2 with ack held off 3 cycles, rdata_in=0xABCD_1234 -> busy high throughout WAIT, rdata=0x0000_ABCD.
REQ-036 The bench SHALL run reset mid-WAIT: reset asserted in WAIT -> dmem_req=0 the next cycle, no rdata_valid, and a subsequent sw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
// Holds the FSM state enum, control bit indices and default timeout.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int LD_LB  = 0;
   localparam int LD_LH  = 1;
   localparam int LD_LW  = 2;
   localparam int LD_LBU = 3;
   localparam int LD_LHU = 4;

   localparam int ST_SB = 0;
   localparam int ST_SH = 1;
   localparam int ST_SW = 2;

   localparam int unsigned DEF_TIMEOUT = 16;

   function automatic logic onehot5(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Pipeline and data-memory signals of the load/store port.
// slave is the port block itself; master is decode plus memory.
interface lsu_mem_port_if;

   logic        memread;
   logic        memwrite;
   logic [4:0]  loadcntrl;
   logic [2:0]  storecntrl;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   logic [31:0] rdata;
   logic        rdata_valid;
   logic        busy;
   logic        fault;

   modport slave (
      input  memread, memwrite, loadcntrl, storecntrl, addr, wdata,
      input  dmem_ack, dmem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output rdata, rdata_valid, busy, fault
   );

   modport master (
      output memread, memwrite, loadcntrl, storecntrl, addr, wdata,
      output dmem_ack, dmem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  rdata, rdata_valid, busy, fault
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data replication and
// load lane extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_st,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_ld,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shift = i_word >> {i_ld_off, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = i_ld_off[1] ? i_word[31:16] : i_word[15:0];

   // Store lanes; i_st is zero for loads, giving a full-word enable.
   always_comb begin
      o_be    = 4'hF;
      o_wdata = i_wdata;
      unique case (1'b1)
         i_st[ST_SB]: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
         end
         i_st[ST_SH]: begin
            o_be    = i_off[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load result from the latched type and byte offset.
   always_comb begin
      o_ldata = i_word;
      unique case (1'b1)
         i_ld[LD_LB]:  o_ldata = {{24{w_byte[7]}}, w_byte};
         i_ld[LD_LH]:  o_ldata = {{16{w_half[15]}}, w_half};
         i_ld[LD_LBU]: o_ldata = {24'd0, w_byte};
         i_ld[LD_LHU]: o_ldata = {16'd0, w_half};
         default:      o_ldata = i_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port between decode and a single-beat data memory.
// Checks requests, runs IDLE/WAIT/RESP and aborts on timeout.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   lsu_mem_port_if.slave bus
);

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [1:0]  r_off;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [4:0]  r_ld;
   logic [31:0] r_rdata;
   logic        r_valid;
   logic        r_fault;

   logic        w_rd;
   logic        w_wr;
   logic        w_both;
   logic        w_any;
   logic        w_ld_oh;
   logic        w_st_oh;
   logic        w_mis_ld;
   logic        w_mis_st;
   logic        w_bad;
   logic        w_accept;
   logic        w_reject;
   logic [2:0]  w_st_sel;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;

   assign w_rd    = bus.memread & ~bus.memwrite;
   assign w_wr    = bus.memwrite & ~bus.memread;
   assign w_both  = bus.memread & bus.memwrite;
   assign w_any   = bus.memread | bus.memwrite;
   assign w_ld_oh = onehot5(bus.loadcntrl);
   assign w_st_oh = onehot5({2'b00, bus.storecntrl});

   assign w_mis_ld = (bus.loadcntrl[LD_LW] & (bus.addr[1:0] != 2'b00))
                   | ((bus.loadcntrl[LD_LH] | bus.loadcntrl[LD_LHU])
                      & bus.addr[0]);
   assign w_mis_st = (bus.storecntrl[ST_SW] & (bus.addr[1:0] != 2'b00))
                   | (bus.storecntrl[ST_SH] & bus.addr[0]);

   assign w_bad = w_both
                | (w_rd & (~w_ld_oh | w_mis_ld))
                | (w_wr & (~w_st_oh | w_mis_st));

   assign w_accept = (r_state == S_IDLE) & w_any & ~w_bad;
   assign w_reject = (r_state == S_IDLE) & w_any & w_bad;
   assign w_st_sel = (w_wr & w_st_oh) ? bus.storecntrl : 3'b000;

   lsu_align u_align (
      .i_st     (w_st_sel),
      .i_off    (bus.addr[1:0]),
      .i_wdata  (bus.wdata),
      .i_ld     (r_ld),
      .i_ld_off (r_off),
      .i_word   (bus.dmem_rdata),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_ldata  (w_ldata)
   );

   assign bus.dmem_req    = r_req;
   assign bus.dmem_we     = r_we;
   assign bus.dmem_addr   = r_addr;
   assign bus.dmem_be     = r_be;
   assign bus.dmem_wdata  = r_wdata;
   assign bus.rdata       = r_rdata;
   assign bus.rdata_valid = r_valid;
   assign bus.fault       = r_fault;
   assign bus.busy        = (r_state == S_WAIT) | w_accept;

   // Transaction FSM with wait counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_off   <= 2'd0;
         r_be    <= 4'd0;
         r_wdata <= 32'd0;
         r_ld    <= 5'd0;
         r_rdata <= 32'd0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_WAIT;
                  r_cnt   <= 8'd0;
                  r_req   <= 1'b1;
                  r_we    <= w_wr;
                  r_addr  <= {bus.addr[31:2], 2'b00};
                  r_off   <= bus.addr[1:0];
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_ld    <= w_rd ? bus.loadcntrl : 5'd0;
               end else if (w_reject) begin
                  r_fault <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.dmem_ack) begin
                  r_req <= 1'b0;
                  if (r_we) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_rdata <= w_ldata;
                     r_valid <= 1'b1;
                     r_state <= S_RESP;
                  end
               end else if (r_cnt == LP_LAST) begin
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
